// File: rtl/smi_self_link_buffer_fifo_m.sv
// rtl/smi_self_link_buffer_fifo_m.sv - SELF link buffer FIFO with circular storage and registered output stage
//
// Purpose:
//   Buffers SELF link beats between a producer and a consumer stage. The
//   output register holds the head entry. A (FifoSize-1)-entry circular
//   store holds the rest, so total capacity is FifoSize.
//   StopLatency > 0 lets an upstream whose stop path is pipelined keep
//   pushing for a few cycles after dataInStop rises. Stop is raised early
//   enough that those late pushes still fit.
//
// Ports:
//   clk           rising-edge clock
//   arstn         asynchronous active-low reset
//   flush         synchronous discard of all contents (priority over push/pop)
//   dataInValid   upstream valid
//   dataIn        upstream data
//   dataInStop    upstream stop (registered)
//   dataOutValid  downstream valid (registered)
//   dataOut       downstream data (registered, not reset)
//   dataOutStop   downstream stop
//   fillLevel     entries held, including the output register (registered)
//   overflow      sticky: a push was dropped because the FIFO was full

module smi_self_link_buffer_fifo_m #(
    parameter int DataWidth     = 8,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 5,
    parameter int StopLatency   = 0
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     flush,
    input  logic                     dataInValid,
    input  logic [DataWidth-1:0]     dataIn,
    output logic                     dataInStop,
    output logic                     dataOutValid,
    output logic [DataWidth-1:0]     dataOut,
    input  logic                     dataOutStop,
    output logic [FifoIndexSize-1:0] fillLevel,
    output logic                     overflow
);

    // Storage excludes the output register.
    localparam int Depth = FifoSize - 1;
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [PtrW-1:0]          PtrLast    = PtrW'(Depth - 1);
    localparam logic [FifoIndexSize-1:0] CountFull  = FifoIndexSize'(FifoSize);
    localparam logic [FifoIndexSize-1:0] StopThresh = FifoIndexSize'(FifoSize - StopLatency);

    // With a latency-tolerant upstream, stop is only advisory. Fullness
    // alone decides whether a push is accepted.
    localparam logic StopIgnored = (StopLatency > 0) ? 1'b1 : 1'b0;

    logic [DataWidth-1:0]     mem_q [0:Depth-1];
    logic [DataWidth-1:0]     out_data_q;

    logic [FifoIndexSize-1:0] count_q,     count_d;
    logic                     stop_q,      stop_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overflow_q,  overflow_d;
    logic [PtrW-1:0]          wr_ptr_q,    wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q,    rd_ptr_d;

    logic                     full;
    logic                     push_req;
    logic                     push;
    logic                     drop;
    logic                     pop;
    logic [FifoIndexSize-1:0] buf_cnt;
    logic                     buf_empty;
    logic                     out_load;
    logic                     load_from_mem;
    logic                     bypass;
    logic                     mem_we;
    logic                     out_we;

    // Non-power-of-2 depths need an explicit wrap. Bit truncation would
    // step into unused addresses.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        full      = (count_q == CountFull);
        push_req  = dataInValid & (~stop_q | StopIgnored);
        push      = push_req & ~full;
        drop      = push_req & full;
        pop       = out_valid_q & ~dataOutStop;

        // Entries held in storage, excluding the output register.
        buf_cnt   = count_q - FifoIndexSize'(out_valid_q);
        buf_empty = (buf_cnt == '0);

        // The output register takes a new head when it is empty or being
        // drained. The oldest stored entry goes first. An incoming beat
        // bypasses storage only when nothing is stored, which keeps strict
        // order and gives latency 1 into an empty FIFO.
        out_load      = ~out_valid_q | pop;
        load_from_mem = out_load & ~buf_empty;
        bypass        = out_load & buf_empty & push;

        count_d     = count_q;
        stop_d      = stop_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_we      = 1'b0;
        out_we      = 1'b0;

        if (flush) begin
            count_d     = '0;
            stop_d      = 1'b0;
            out_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end else begin
            count_d    = count_q + FifoIndexSize'(push) - FifoIndexSize'(pop);
            stop_d     = (count_d >= StopThresh);
            overflow_d = overflow_q | drop;
            mem_we     = push & ~bypass;
            out_we     = load_from_mem | bypass;
            if (out_load) begin
                out_valid_d = load_from_mem | bypass;
            end
            if (load_from_mem) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (mem_we) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
        end
    end

    // Stop comes out of reset asserted and releases on the first edge.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q     <= '0;
            stop_q      <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            count_q     <= count_d;
            stop_q      <= stop_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Data path is not reset. When the store is full, wr_ptr equals rd_ptr.
    // A same-cycle read and write then returns the old entry, which is the
    // one being popped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
        if (out_we) begin
            out_data_q <= load_from_mem ? mem_q[rd_ptr_q] : dataIn;
        end
    end

    assign dataInStop   = stop_q;
    assign dataOutValid = out_valid_q;
    assign dataOut      = out_data_q;
    assign fillLevel    = count_q;
    assign overflow     = overflow_q;

endmodule
